// File: rtl/fifo_reader.sv
// Drains a fifo through a two-entry skid buffer onto a registered valid/ready stream.
// Optional even parity on m_parity_o when FIFO_READER_PARITY_EN is defined.
module fifo_reader #(
    parameter int unsigned WordLength = 8,
    parameter int unsigned BurstLen   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [WordLength-1:0] fifo_r_data_i,
    output logic                  fifo_rd_o,
    output logic [WordLength-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  m_parity_o,
    output logic                  busy_o
);

    localparam int unsigned CntW = (BurstLen > 1) ? $clog2(BurstLen) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BurstLen - 1);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e                state_q, state_d;
    logic [WordLength-1:0] data_q, data_d;
    logic [WordLength-1:0] skid_q, skid_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  pop;
    logic                  hs;

    // Pop depends only on registered state, never on m_ready_i.
    assign pop       = ~fifo_empty_i & (state_q != StTwo) & ~rst_i;
    assign fifo_rd_o = pop;
    assign m_valid_o = (state_q != StEmpty);
    assign hs        = m_valid_o & m_ready_i;
    assign m_data_o  = data_q;
    assign m_last_o  = m_valid_o & (cnt_q == CntMax);
    assign busy_o    = m_valid_o | (cnt_q != '0);

`ifdef FIFO_READER_PARITY_EN
    assign m_parity_o = m_valid_o & (^data_q);
`else
    assign m_parity_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StEmpty: begin
                if (pop) begin
                    state_d = StOne;
                    data_d  = fifo_r_data_i;
                end
            end
            StOne: begin
                if (pop && !hs) begin
                    state_d = StTwo;
                    skid_d  = fifo_r_data_i;
                end else if (pop && hs) begin
                    data_d = fifo_r_data_i;
                end else if (hs) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (hs) begin
                    state_d = StOne;
                    data_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (hs) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            data_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and random checks of fifo_reader against a behavioural fifo and scoreboard.
module tb_fifo_reader;

`ifdef FIFO_READER_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       m_ready;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_parity;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int underflow_cnt = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];

    logic       mon_en = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         mon_cnt = 0;

    always #5 clk = ~clk;

    fifo_reader #(
        .WordLength(8),
        .BurstLen  (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_empty_i (fifo_empty),
        .fifo_r_data_i(fifo_data),
        .fifo_rd_o    (fifo_rd),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last),
        .m_parity_o   (m_parity),
        .busy_o       (busy)
    );

    // Behavioural fifo; outputs change only in the NBA region to avoid racing the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= 8'h00;
        end else begin
            if (fifo_rd) begin
                if (fq.size() == 0) underflow_cnt++;
                else void'(fq.pop_front());
            end
            if (wr_en) fq.push_back(wr_data);
            fifo_empty <= (fq.size() == 0);
            fifo_data  <= (fq.size() != 0) ? fq[0] : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] d, input logic last);
        chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, m_data}, {24'd0, d});
        chk({tag, "_last"}, {31'd0, m_last}, {31'd0, last});
        chk({tag, "_par"}, {31'd0, m_parity}, {31'd0, ParEn & (^d)});
    endtask

    // Scoreboard monitor for the random phase; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rnd_no_underflow", {31'd0, fifo_rd & fifo_empty}, 32'd0);
            if (prev_valid && !prev_ready) begin
                chk("rnd_stall_valid", {31'd0, m_valid}, 32'd1);
                chk("rnd_stall_data", {24'd0, m_data}, {24'd0, prev_data});
            end
            if (m_valid) begin
                chk("rnd_last", {31'd0, m_last}, {31'd0, (mon_cnt == 3)});
                chk("rnd_par", {31'd0, m_parity}, {31'd0, ParEn & (^m_data)});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_beat", 32'd1, 32'd0);
                end else begin
                    chk("rnd_order", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                end
                mon_cnt = (mon_cnt == 3) ? 0 : mon_cnt + 1;
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int sent;
        int cyc;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        m_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_par", {31'd0, m_parity}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
        rst = 1'b0;
        step();

        // Three words written under backpressure, then reset asserted asynchronously.
        wr_en = 1'b1;
        wr_data = 8'h31; step();
        wr_data = 8'h32; step();
        wr_data = 8'h33; step();
        wr_en = 1'b0;
        chk("pre_rst_data", {24'd0, m_data}, 32'h31);
        chk("pre_rst_rd", {31'd0, fifo_rd}, 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("async_rst_data", {24'd0, m_data}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_rd", {31'd0, fifo_rd}, 32'd0);
        step();
        chk("in_rst_rd", {31'd0, fifo_rd}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_rd", {31'd0, fifo_rd}, 32'd0);
        chk("post_rst_valid", {31'd0, m_valid}, 32'd0);

        // Streaming 0x01..0x08 with ready held high.
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_en = (k < 8);
            wr_data = 8'(k + 1);
            step();
            if (k == 0) chk("str_lat", {31'd0, m_valid}, 32'd0);
            else if (k <= 8) chk_beat("str", 8'(k), (k == 4) || (k == 8));
            else begin
                chk("str_end_valid", {31'd0, m_valid}, 32'd0);
                chk("str_end_busy", {31'd0, busy}, 32'd0);
            end
        end

        // Backpressure: 0x10..0x15 with ready low for 10 cycles.
        m_ready = 1'b0;
        pops = 0;
        for (int k = 0; k < 10; k++) begin
            wr_en = (k < 6);
            wr_data = 8'(8'h10 + k);
            step();
            pops += int'(fifo_rd);
            if (k >= 1) chk("bp_hold", {24'd0, m_data}, 32'h10);
        end
        wr_en = 1'b0;
        chk("bp_pops", pops, 32'd2);
        chk("bp_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_rd_off", {31'd0, fifo_rd}, 32'd0);
        chk("bp_fifo_words", fq.size(), 32'd4);
        chk("bp_last10", {31'd0, m_last}, 32'd0);
        m_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            chk_beat("bp_drain", 8'(8'h11 + j), (j == 2));
        end
        step();
        chk("bp_end_valid", {31'd0, m_valid}, 32'd0);
        chk("bp_midburst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midburst_rst_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Gap mid-burst.
        for (int k = 0; k < 11; k++) begin
            wr_en = (k < 2) || (k == 7) || (k == 8);
            wr_data = (k == 0) ? 8'hA0 : (k == 1) ? 8'hA1 : (k == 7) ? 8'hA2 : 8'hA3;
            step();
            if (k == 1) chk_beat("gap_a0", 8'hA0, 1'b0);
            else if (k == 2) chk_beat("gap_a1", 8'hA1, 1'b0);
            else if (k >= 3 && k <= 7) begin
                chk("gap_valid", {31'd0, m_valid}, 32'd0);
                chk("gap_busy", {31'd0, busy}, 32'd1);
            end else if (k == 8) chk_beat("gap_a2", 8'hA2, 1'b0);
            else if (k == 9) chk_beat("gap_a3", 8'hA3, 1'b1);
            else if (k == 10) chk("gap_end_busy", {31'd0, busy}, 32'd0);
        end
        wr_en = 1'b0;

        // Parity directed values.
        m_ready = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h07; step();
        wr_data = 8'h03; step();
        wr_en = 1'b0;
        step();
        chk("par_07", {31'd0, m_parity}, {31'd0, ParEn});
        m_ready = 1'b1;
        step();
        chk("par_03_data", {24'd0, m_data}, 32'h03);
        chk("par_03", {31'd0, m_parity}, 32'd0);
        step();
        chk("par_idle", {31'd0, m_parity}, 32'd0);

        // Random stress against the scoreboard monitor.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        mon_en = 1'b1;
        sent = 0;
        cyc = 0;
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            wr_en = (sent < 1000) && ($urandom_range(0, 1) == 1);
            if (wr_en) begin
                wr_data = 8'($urandom_range(0, 255));
                exp_q.push_back(wr_data);
                sent++;
            end
            m_ready = ($urandom_range(0, 1) == 1);
            step();
            cyc++;
        end
        wr_en = 1'b0;
        m_ready = 1'b1;
        step();
        mon_en = 1'b0;
        chk("rnd_drain", exp_q.size(), 32'd0);
        chk("rnd_sent", sent, 32'd1000);
        chk("underflow_total", underflow_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side companion to the `fifo` block. It drains a `fifo` instance through that block's `rd_i`/`r_data_o`/`empty_o` interface and presents the words downstream as a registered valid/ready stream. A two-entry skid buffer sustains one word per cycle with no combinational path from `m_ready_i` to `fifo_rd_o`. A beat counter marks every `BurstLen`-th word with `m_last_o`.

## Interface
- `WordLength`, default 8: data width; must match the connected `fifo`.
- `BurstLen`, default 4: words per burst; legal values are 1 to 256.
- `clk_i` input, 1 bit: clock. Every register updates on the rising edge.
- `rst_i` input, 1 bit: asynchronous, active-high reset.
- `fifo_empty_i` input, 1 bit: driven by `empty_o` of the `fifo`.
- `fifo_r_data_i` input, `WordLength` bits: driven by `r_data_o` of the `fifo`. It is valid combinationally while `fifo_empty_i` = 0.
- `fifo_rd_o` output, 1 bit: drives `rd_i` of the `fifo`. One high cycle pops one word.
- `m_data_o` output, `WordLength` bits: stream data.
- `m_valid_o` output, 1 bit: stream valid.
- `m_ready_i` input, 1 bit: stream ready from the consumer.
- `m_last_o` output, 1 bit: high on the final beat of a burst.
- `m_parity_o` output, 1 bit: parity of `m_data_o`. See Configuration.
- `busy_o` output, 1 bit: high when a word is buffered or a burst is partly sent.

## Operation
- Storage: output register (`m_data_o`) plus one skid register.
- Occupancy FSM states:
  - EMPTY: nothing buffered.
  - ONE: output register valid.
  - TWO: output and skid registers both valid.
- Pop rule: `fifo_rd_o` = `~fifo_empty_i & (state != TWO) & ~rst_i`. The word is captured from `fifo_r_data_i` on the same edge.
- Handshake: a beat transfers when `m_valid_o & m_ready_i` are high at a rising edge. `m_valid_o` = (state != EMPTY).
- Once `m_valid_o` is asserted, it and `m_data_o` hold stable until the handshake.
- Transitions (pop = `fifo_rd_o`, hs = handshake):
  - EMPTY: pop -> ONE, word loaded into the output register. Otherwise stay in EMPTY.
  - ONE:
    - pop & ~hs -> TWO, word loaded into the skid register.
    - pop & hs -> stay in ONE, output register takes the new word.
    - ~pop & hs -> EMPTY.
    - Otherwise stay in ONE.
  - TWO: hs -> ONE, output register takes the skid word. Otherwise stay in TWO. No pop occurs in TWO.
- Ordering: words reach `m_data_o` strictly in FIFO pop order.
- Beat counter:
  - Width is `$clog2(BurstLen)`, with a minimum of 1 bit.
  - Increments on each handshake.
  - Wraps to 0 on the handshake where the count equals `BurstLen`-1.
  - `m_last_o` = `m_valid_o & (cnt == BurstLen-1)`.
  - With `BurstLen` = 1, every beat is last.
- `busy_o` = (state != EMPTY) | (cnt != 0).

## Timing
- Reset values: state EMPTY, counter 0, skid register 0. All outputs are 0: `m_data_o`, `m_valid_o`, `m_last_o`, `m_parity_o`, `busy_o`, `fifo_rd_o`.
- Reset mid-burst: buffered words are discarded and the counter clears. The `fifo` is reset by the same `rst_i`.
- Latency: `fifo_empty_i` falls in cycle N -> `fifo_rd_o` is high in cycle N -> `m_valid_o` is high in cycle N+1.
- Throughput: one word per cycle while the FIFO is non-empty and `m_ready_i` is held high.
- Backpressure: with `m_ready_i` low, at most 2 words are popped. After that `fifo_rd_o` stays 0.
- Restart: when `m_ready_i` rises with state TWO, the handshake completes at that edge. `fifo_rd_o` is high again in the following cycle.
- FIFO empty during a burst: `m_valid_o` drops, and the counter holds its value until more data arrives. A burst is never closed early.
- `fifo_rd_o` is never high while `fifo_empty_i` = 1, so no underflow requests reach the `fifo`.

## Configuration
- Macro: `FIFO_READER_PARITY_EN`.
- Defined: `m_parity_o` = XOR reduction of `m_data_o`. This is even parity: the count of 1s across data plus parity is even. The value is valid whenever `m_valid_o` = 1 and is 0 when `m_valid_o` = 0.
- Undefined: `m_parity_o` is tied to 0 and no parity logic is synthesized. Port list and all other behaviour are unchanged.

## Test plan
- Reset check: assert `rst_i` with the FIFO holding 3 words -> all outputs are 0 and `fifo_rd_o` = 0 during reset. In the first cycle after release, `fifo_rd_o` = 0 (the FIFO is also cleared).
- Streaming: write 0x01..0x08 with `m_ready_i` held at 1 and `BurstLen` = 4 -> the 8 words appear on consecutive cycles in order. `m_last_o` is high on 0x04 and 0x08, and `busy_o` is 0 after 0x08.
- Backpressure: write 0x10..0x15 with `m_ready_i` = 0 for 10 cycles -> exactly 2 pops. `m_data_o` holds 0x10 and the FIFO keeps 4 words. Raising `m_ready_i` delivers 0x10..0x15 back-to-back.
- Gap mid-burst: write 0xA0 and 0xA1, wait 5 cycles, then write 0xA2 and 0xA3 -> `m_valid_o` is low during the gap. `m_last_o` is high only on 0xA3, and `busy_o` stays 1 through the gap.
- Random stress: random `m_ready_i` (50%) and random writes over 1000 words -> scoreboard order is exact, there are no `fifo_rd_o` pulses while empty, and `m_data_o` is stable during every stall.
- Parity (`FIFO_READER_PARITY_EN` defined): data 0x07 -> `m_parity_o` = 1. Data 0x03 -> `m_parity_o` = 0. Macro undefined -> `m_parity_o` is always 0.
